// File: rtl/led_serial_pkg.sv
// rtl/led_serial_pkg.sv - shared constants, frame states and helpers for the LED serial receiver
package led_serial_pkg;

    localparam int LED_FRAME_W = 8;
    localparam logic [31:0] BRIGHTNESS_TICKS = 32'h30D40;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_FULL    = 2'd2,
        ST_OVERRUN = 2'd3
    } frame_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/led_serial_receiver_if.sv
// rtl/led_serial_receiver_if.sv - LED serial link lines (sdi/sclk/latch/n_output_enable)
interface led_serial_receiver_if;
    logic sdi;
    logic sclk;
    logic latch;
    logic n_output_enable;

    modport master (output sdi, output sclk, output latch, output n_output_enable);
    modport slave  (input  sdi, input  sclk, input  latch, input  n_output_enable);
endinterface

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - multi-flop synchroniser with registered-copy rise/fall pulse detection
module edge_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = chain[STAGES-1] & ~prev;
    assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/led_serial_receiver.sv
// rtl/led_serial_receiver.sv - oversampling LED shift-register receiver with latch, output enable and on-time meter
module led_serial_receiver
    import led_serial_pkg::*;
#(
    parameter int WIDTH       = LED_FRAME_W,
    parameter int SYNC_STAGES = 2,
    parameter int TICK_W      = 32
) (
    input  logic                 CLOCK_5,
    input  logic                 n_reset,
    led_serial_receiver_if.slave link,
    output logic [WIDTH-1:0]     data_out,
    output logic [WIDTH-1:0]     leds,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 overrun,
    output logic [7:0]           bit_count,
    output logic [TICK_W-1:0]    last_on_ticks
);

    logic sdi_s, sdi_rise_unused, sdi_fall_unused;
    logic sclk_q_unused, sclk_rise, sclk_fall_unused;
    logic latch_q_unused, latch_rise, latch_fall_unused;
    logic n_oe_s, oe_end, oe_start_unused;

    edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk(CLOCK_5), .rst_n(n_reset), .d(link.sdi),
        .q(sdi_s), .rise(sdi_rise_unused), .fall(sdi_fall_unused));
    edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(CLOCK_5), .rst_n(n_reset), .d(link.sclk),
        .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall_unused));
    edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_latch (
        .clk(CLOCK_5), .rst_n(n_reset), .d(link.latch),
        .q(latch_q_unused), .rise(latch_rise), .fall(latch_fall_unused));
    edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_noe (
        .clk(CLOCK_5), .rst_n(n_reset), .d(link.n_output_enable),
        .q(n_oe_s), .rise(oe_end), .fall(oe_start_unused));

    logic              oe;
    frame_state_e      state, state_nx;
    logic [7:0]        count_nx;
    logic [WIDTH-1:0]  shift_reg, shift_nx;
    logic              frame_good;
    logic [TICK_W-1:0] on_cnt;

    assign oe = ~n_oe_s;

    // A same-cycle sclk rise is folded in before the latch looks at the frame.
    always_comb begin
        count_nx = sclk_rise ? sat_inc8(bit_count) : bit_count;
        shift_nx = sclk_rise ? {sdi_s, shift_reg[WIDTH-1:1]} : shift_reg;
    end

    always_ff @(posedge CLOCK_5 or negedge n_reset) begin
        if (!n_reset) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (latch_rise) begin
            state_nx = ST_IDLE;
        end else if (sclk_rise) begin
            case (state)
                ST_IDLE, ST_SHIFT: state_nx = (count_nx == 8'(WIDTH)) ? ST_FULL : ST_SHIFT;
                ST_FULL:           state_nx = ST_OVERRUN;
                default:           state_nx = ST_OVERRUN;
            endcase
        end
    end

    always_comb begin
        overrun    = (state == ST_OVERRUN);
        frame_good = (count_nx == 8'(WIDTH));
    end

    always_ff @(posedge CLOCK_5 or negedge n_reset) begin
        if (!n_reset) begin
            shift_reg   <= '0;
            bit_count   <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            leds        <= '0;
        end else begin
            shift_reg   <= shift_nx;
            bit_count   <= latch_rise ? 8'd0 : count_nx;
            if (latch_rise) data_out <= shift_nx;
            data_valid  <= latch_rise & frame_good;
            frame_error <= latch_rise & ~frame_good;
            leds        <= data_out & {WIDTH{oe}};
        end
    end

    always_ff @(posedge CLOCK_5 or negedge n_reset) begin
        if (!n_reset) begin
            on_cnt        <= '0;
            last_on_ticks <= '0;
        end else if (oe_end) begin
            last_on_ticks <= on_cnt;
            on_cnt        <= '0;
        end else if (oe && on_cnt != {TICK_W{1'b1}}) begin
            on_cnt <= on_cnt + 1'b1;
        end
    end

endmodule
